// File: rtl/data_mem_responder.sv
// Word-wide load/store responder with fixed wait states, alignment/range checking
// and valid/ready handshakes on both request and response sides.
//
// state  | meaning
// S_IDLE | ready for a request; request fields latched on accept
// S_WAIT | counting down wait states; access performed when wait_cnt hits 1
// S_RESP | response presented; held until resp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        access;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [IDX_W-1:0] acc_idx;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request fields rather than the not-yet-latched copies.
  assign acc_write = (state == S_IDLE) ? req_write : write_q;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_n    = state;
    access     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req_ready = ~reset;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_n = S_RESP;
            access  = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_n = S_RESP;
          access  = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && req_valid) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (access) begin
        resp_error <= acc_err;
        resp_rdata <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
      end else if (state == S_RESP && resp_ready) begin
        resp_rdata <= 32'd0;
        resp_error <= 1'b0;
      end
    end
  end

  // Storage has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && access && acc_write && !acc_err)
      mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with zero wait states, sharing clock and reset.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic        req_valid_a, req_ready_a, req_write_a, resp_valid_a, resp_ready_a, resp_error_a, busy_a;
  logic [31:0] req_addr_a, req_wdata_a, resp_rdata_a;
  logic        req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_error_b, busy_b;
  logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .resp_rdata(resp_rdata_a), .resp_error(resp_error_a), .busy(busy_a)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_rdata(resp_rdata_b), .resp_error(resp_error_b), .busy(busy_b)
  );

  // lat = number of rising edges from the accept edge to the first edge at
  // which resp_valid is high (WAIT_STATES+1); -1 if no response arrives.
  task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wdata;
    resp_ready_a = 1'b0;
    n = 0;
    while (!req_ready_a && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = -1; rdata = 'x; err = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      req_valid_a = 1'b0;
      if (resp_valid_a) begin lat = i; break; end
    end
    if (lat > 0) begin
      rdata = resp_rdata_a; err = resp_error_a;
      resp_ready_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready_a = 1'b0;
    end
  endtask

  task automatic txn_b(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = wr; req_addr_b = addr; req_wdata_b = wdata;
    resp_ready_b = 1'b0;
    n = 0;
    while (!req_ready_b && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = -1; rdata = 'x; err = 1'bx;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      req_valid_b = 1'b0;
      if (resp_valid_b) begin lat = i; break; end
    end
    if (lat > 0) begin
      rdata = resp_rdata_b; err = resp_error_b;
      resp_ready_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h10; req_wdata_a = 32'h1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready_a !== 1'b0) begin bad++; $display("FAIL reset_req_ready_low got=%b exp=0", req_ready_a); end
    rst = 1'b0;
    req_valid_a = 1'b0;
    #1;
    total++;
    if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready_high got=%b/%b exp=1/1", req_ready_a, req_ready_b);
    end
    total++;
    if (resp_valid_a !== 1'b0 || resp_rdata_a !== 32'd0 || resp_error_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_outputs_a got v=%b d=%h e=%b b=%b exp 0", resp_valid_a, resp_rdata_a, resp_error_a, busy_a);
    end
    total++;
    if (resp_valid_b !== 1'b0 || resp_rdata_b !== 32'd0 || resp_error_b !== 1'b0 || busy_b !== 1'b0) begin
      bad++; $display("FAIL reset_outputs_b got v=%b d=%h e=%b b=%b exp 0", resp_valid_b, resp_rdata_b, resp_error_b, busy_b);
    end
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_wins_over_req busy=%b exp=0", busy_a); end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    txn_a(1'b1, 32'h10, 32'hDEADBEEF, d, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'd0) begin
      bad++; $display("FAIL store_0x10 got lat=%0d err=%b rdata=%h exp lat=3 err=0 rdata=0", lat, e, d);
    end
    txn_a(1'b0, 32'h10, 32'h0, d, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL load_0x10 got lat=%0d err=%b rdata=%h exp lat=3 err=0 rdata=deadbeef", lat, e, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [3];
    int acc_cyc [3];
    int rsp_cyc [3];
    int k, r;
    logic [31:0] d; logic e; int lat;
    dat[0] = 32'h0000_1111; dat[1] = 32'h2222_0000; dat[2] = 32'hA5A5_5A5A;
    k = 0; r = 0;
    for (int j = 0; j < 3; j++) begin acc_cyc[j] = -100; rsp_cyc[j] = -100; end
    @(negedge clk);
    resp_ready_b = 1'b1;
    for (int i = 0; i < 30 && r < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid_b && r < 3) begin
        total++;
        if (resp_error_b !== 1'b0 || resp_rdata_b !== 32'd0) begin
          bad++; $display("FAIL b2b_store_resp%0d got err=%b rdata=%h exp 0/0", r, resp_error_b, resp_rdata_b);
        end
        rsp_cyc[r] = cyc; r++;
      end
      req_valid_b = (k < 3);
      req_write_b = 1'b1;
      req_addr_b  = 32'(4 * k);
      req_wdata_b = (k < 3) ? dat[k] : 32'd0;
      if (req_ready_b && k < 3) begin acc_cyc[k] = cyc; k++; end
    end
    @(negedge clk);
    req_valid_b = 1'b0; resp_ready_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (rsp_cyc[j] - acc_cyc[j] !== 1) begin
        bad++; $display("FAIL b2b_latency%0d got=%0d exp=1", j, rsp_cyc[j] - acc_cyc[j]);
      end
    end
    total++;
    if (acc_cyc[1] - acc_cyc[0] !== 2 || acc_cyc[2] - acc_cyc[1] !== 2) begin
      bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=2,2", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
    for (int j = 0; j < 3; j++) begin
      txn_b(1'b0, 32'(4 * j), 32'd0, d, e, lat);
      total++;
      if (lat !== 1 || e !== 1'b0 || d !== dat[j]) begin
        bad++; $display("FAIL b2b_reload%0d got lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=%h", j, lat, e, d, dat[j]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    txn_a(1'b1, 32'h12, 32'hCAFEF00D, d, e, lat);
    total++;
    if (e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL misaligned_store got err=%b rdata=%h exp 1/0", e, d); end
    txn_a(1'b0, 32'h10, 32'd0, d, e, lat);
    total++;
    if (e !== 1'b0 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL after_misaligned got err=%b rdata=%h exp 0/deadbeef", e, d); end
    txn_a(1'b0, 32'h400, 32'd0, d, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL load_0x400 got lat=%0d err=%b rdata=%h exp 3/1/0", lat, e, d); end
    txn_a(1'b1, 32'h3FC, 32'h1234_5678, d, e, lat);
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL store_0x3fc got err=%b exp=0", e); end
    txn_a(1'b0, 32'h3FC, 32'd0, d, e, lat);
    total++;
    if (e !== 1'b0 || d !== 32'h1234_5678) begin bad++; $display("FAIL load_0x3fc got err=%b rdata=%h exp 0/12345678", e, d); end
    txn_a(1'b1, 32'h400, 32'hFFFF_FFFF, d, e, lat);
    txn_a(1'b0, 32'h0, 32'd0, d, e, lat);
    total++;
    if (d === 32'hFFFF_FFFF) begin bad++; $display("FAIL no_wrap got rdata=%h exp not ffffffff", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; int lat; int n;
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 32'h10; resp_ready_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    n = 0;
    while (!resp_valid_a && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid_a !== 1'b1 || resp_rdata_a !== 32'hDEADBEEF || resp_error_a !== 1'b0 || req_ready_a !== 1'b0) begin
        bad++; $display("FAIL backpressure_hold%0d got v=%b d=%h e=%b rr=%b exp 1/deadbeef/0/0",
                        i, resp_valid_a, resp_rdata_a, resp_error_a, req_ready_a);
      end
      req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h10; req_wdata_a = 32'h0BAD_0BAD;
      @(negedge clk);
    end
    req_valid_a = 1'b0; resp_ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready_a = 1'b0;
    total++;
    if (resp_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL backpressure_release got v=%b busy=%b exp 0/0", resp_valid_a, busy_a);
    end
    txn_a(1'b0, 32'h10, 32'd0, d, e, lat);
    total++;
    if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL backpressure_ignored_req got=%h exp=deadbeef", d); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] d; logic e; int lat;
    txn_a(1'b1, 32'h20, 32'h11, d, e, lat);
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h20; req_wdata_a = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    total++;
    if (busy_a !== 1'b1 || resp_valid_a !== 1'b0) begin bad++; $display("FAIL in_wait got busy=%b v=%b exp 1/0", busy_a, resp_valid_a); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (resp_valid_a !== 1'b0 || resp_rdata_a !== 32'd0 || resp_error_a !== 1'b0 || busy_a !== 1'b0 || req_ready_a !== 1'b1) begin
      bad++; $display("FAIL reset_wait_outputs got v=%b d=%h e=%b b=%b rr=%b exp 0/0/0/0/1",
                      resp_valid_a, resp_rdata_a, resp_error_a, busy_a, req_ready_a);
    end
    txn_a(1'b0, 32'h20, 32'd0, d, e, lat);
    total++;
    if (d !== 32'h11 || e !== 1'b0) begin bad++; $display("FAIL reset_wait_no_commit got=%h exp=00000011", d); end
  endtask

  task automatic test_reset_resp();
    logic [31:0] d; logic e; int lat; int n;
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h24; req_wdata_a = 32'h77; resp_ready_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    n = 0;
    while (!resp_valid_a && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (resp_valid_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL reset_resp_drop got v=%b busy=%b exp 0/0", resp_valid_a, busy_a); end
    txn_a(1'b0, 32'h24, 32'd0, d, e, lat);
    total++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'h77) begin
      bad++; $display("FAIL reset_resp_next_load got lat=%0d err=%b rdata=%h exp 3/0/00000077", lat, e, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; resp_ready_a = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; resp_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_wait();
    test_reset_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
